// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and FSM state type for the MEM-stage data memory

package dmem_pkg;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-enable / store-lane replication and load extraction/extension

module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic              unsigned_ld,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0] wlanes,
  output logic [DATA_W-1:0] ldata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] shifted;

  always_comb begin
    be      = '0;
    wlanes  = wdata;
    ldata   = '0;
    shifted = rword >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin
        be = NB'(1) << offset;
        for (int i = 0; i < NB; i++) wlanes[8*i +: 8] = wdata[7:0];
        ldata = unsigned_ld ? DATA_W'(shifted[7:0]) : DATA_W'($signed(shifted[7:0]));
      end
      SZ_HALF: begin
        // halves are only ever stored at even offsets, so lane parity picks the byte
        be = NB'(3) << offset;
        for (int i = 0; i < NB; i++) wlanes[8*i +: 8] = wdata[8*(i%2) +: 8];
        ldata = unsigned_ld ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      end
      default: begin
        be     = '1;
        wlanes = wdata;
        ldata  = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - MEM-stage data memory with sub-word access, clear engine and debug port

module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 32,
  parameter int PRELOAD_IDX = 20,
  parameter logic [DATA_W-1:0] PRELOAD_VAL = 32'h0000_0AAA,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              ready,
  input  logic              dbg_on,
  input  logic [IDX_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_valid
);

  localparam int NB        = DATA_W / 8;
  localparam int MEM_BYTES = DEPTH * NB;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] PRE_IDX  = IDX_W'(PRELOAD_IDX);

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  offset;
  logic              out_of_range;
  logic              misaligned;
  logic              addr_err;
  logic              wr_req;
  logic [DATA_W-1:0] rword;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wlanes;
  logic [DATA_W-1:0] ldata;

  assign idx          = addr[OFF_W +: IDX_W];
  assign offset       = addr[OFF_W-1:0];
  assign out_of_range = {1'b0, addr} >= (ADDR_W + 1)'(MEM_BYTES);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = offset[0];
      default: misaligned = (offset != '0);
    endcase
  end

  assign addr_err = out_of_range | misaligned;
  assign wr_req   = (state == RUN) && !dbg_on && (mem_op == OP_WRITE) && !addr_err;
  assign rword    = mem[dbg_on ? dbg_addr : idx];

  dmem_lane_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_align (
    .size        (size),
    .offset      (offset),
    .wdata       (wdata),
    .unsigned_ld (unsigned_ld),
    .rword       (rword),
    .be          (be),
    .wlanes      (wlanes),
    .ldata       (ldata)
  );

  // Storage has no reset of its own; the clear engine initialises it, and rst blocks in-flight writes.
  always_ff @(negedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
        if (clr_idx == LAST_IDX) mem[PRE_IDX] <= PRELOAD_VAL;
      end else if (wr_req) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      ready     <= 1'b0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
      dbg_data  <= '0;
      dbg_valid <= 1'b0;
    end else begin
      rvalid    <= 1'b0;
      dbg_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (dbg_on) begin
            dbg_data  <= rword;
            dbg_valid <= 1'b1;
          end else if (mem_op == OP_WRITE) begin
            err <= addr_err;
          end else if (mem_op == OP_READ) begin
            err    <= addr_err;
            rdata  <= addr_err ? '0 : ldata;
            rvalid <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bank.sv
// tb/tb_dmem_bank.sv - randomized self-checking bench for dmem_bank against a byte-array model

module tb_dmem_bank;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mem_op = OP_IDLE;
  logic [1:0]        size = SZ_WORD;
  logic              unsigned_ld = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              err;
  logic              ready;
  logic              dbg_on = 1'b0;
  logic [IDX_W-1:0]  dbg_addr = '0;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_valid;

  dmem_bank #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .PRELOAD_IDX (20),
    .PRELOAD_VAL (32'h0000_0AAA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_op      (mem_op),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .err         (err),
    .ready       (ready),
    .dbg_on      (dbg_on),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_valid   (dbg_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mb [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 128; i++) mb[i] = 8'h00;
    mb[80] = 8'hAA;
    mb[81] = 8'h0A;
  endfunction

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    if (a >= 32'd128) return 1'b1;
    return (a % nbytes_of(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    longint v = 0;
    int n = nbytes_of(sz);
    if (model_err(a, sz)) return 32'h0;
    for (int k = n - 1; k >= 0; k--) v = v * 256 + mb[a + k];
    if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    if (model_err(a, sz)) return;
    for (int k = 0; k < nbytes_of(sz); k++) mb[a + k] = 8'(wd >> (8 * k));
  endfunction

  function automatic logic [31:0] model_word(input int wi);
    return {mb[4*wi+3], mb[4*wi+2], mb[4*wi+1], mb[4*wi]};
  endfunction

  task automatic mem_access(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    exp_e = model_err(a, sz);
    exp_d = model_load(a, sz, uns);
    mem_op = op; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    @(negedge clk); #1;
    mem_op = OP_IDLE;
    if (op == OP_READ) begin
      check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
      check({tag, "_rdata"}, rdata, exp_d);
      check({tag, "_err"}, 32'(err), 32'(exp_e));
    end else if (op == OP_WRITE) begin
      check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
      check({tag, "_err"}, 32'(err), 32'(exp_e));
      model_store(a, sz, wd);
    end else begin
      check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    end
  endtask

  task automatic dbg_access(input logic [4:0] wi, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input string tag);
    logic [31:0] exp_d;
    exp_d = model_word(int'(wi));
    dbg_on = 1'b1; dbg_addr = wi; mem_op = op; size = SZ_WORD; addr = a; wdata = wd;
    @(negedge clk); #1;
    dbg_on = 1'b0; mem_op = OP_IDLE;
    check({tag, "_dbg_valid"}, 32'(dbg_valid), 32'd1);
    check({tag, "_dbg_data"}, dbg_data, exp_d);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int edges = 0;
    bit noisy = 1'b0;
    while (!ready && edges < 100) begin
      @(negedge clk); #1;
      edges++;
      if (!ready) noisy |= rvalid | dbg_valid | err;
    end
    check({tag, "_clear_edges"}, 32'(edges), 32'd32);
    check({tag, "_clear_quiet"}, 32'(noisy), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  op;
    int          r;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dbg_data", dbg_data, 32'h0);
    check("rst_dbg_valid", 32'(dbg_valid), 32'd0);

    // stray traffic during the clear phase must be ignored
    mem_op = OP_WRITE; size = SZ_WORD; addr = 32'h0; wdata = 32'hFFFF_FFFF;
    dbg_on = 1'b1; dbg_addr = 5'd0;
    rst = 1'b0;
    wait_ready("init");
    mem_op = OP_IDLE; dbg_on = 1'b0;
    model_clear();

    dbg_access(5'd20, OP_IDLE, 32'h0, 32'h0, "dbg20");
    @(negedge clk); #1;
    check("dbg_pulse_one_cycle", 32'(dbg_valid), 32'd0);
    dbg_access(5'd5, OP_IDLE, 32'h0, 32'h0, "dbg5");
    mem_access(OP_READ, SZ_WORD, 1'b0, 32'h0, 32'h0, "lw0_after_clear");

    mem_access(OP_WRITE, SZ_WORD, 1'b0, 32'h10, 32'h8badf00d, "sw10");
    mem_access(OP_READ,  SZ_BYTE, 1'b0, 32'h13, 32'h0, "lb13");
    mem_access(OP_READ,  SZ_BYTE, 1'b1, 32'h13, 32'h0, "lbu13");
    mem_access(OP_READ,  SZ_HALF, 1'b0, 32'h10, 32'h0, "lh10");
    mem_access(OP_READ,  SZ_HALF, 1'b1, 32'h12, 32'h0, "lhu12");
    check("lb13_value", model_load(32'h13, SZ_BYTE, 1'b0), 32'hFFFFFF8B);

    mem_access(OP_WRITE, SZ_WORD, 1'b0, 32'h0, 32'h0, "sw0");
    mem_access(OP_WRITE, SZ_BYTE, 1'b0, 32'h1, 32'h1234, "sb1");
    mem_access(OP_WRITE, SZ_HALF, 1'b0, 32'h2, 32'hBEEF, "sh2");
    mem_access(OP_READ,  SZ_WORD, 1'b0, 32'h0, 32'h0, "lw0_merge");
    check("lw0_merge_exact", rdata, 32'hBEEF3400);

    mem_access(OP_WRITE, SZ_WORD, 1'b0, 32'h7C, 32'h5A5A_1234, "sw7c");
    mem_access(OP_READ,  SZ_WORD, 1'b0, 32'h6, 32'h0, "lw6_misaligned");
    @(negedge clk); #1;
    check("idle_rvalid_drop", 32'(rvalid), 32'd0);
    check("idle_err_hold", 32'(err), 32'd1);
    mem_access(OP_WRITE, SZ_HALF, 1'b0, 32'h81, 32'hFFFF, "sh81");
    mem_access(OP_READ,  SZ_WORD, 1'b0, 32'h80, 32'h0, "lw80_range");
    mem_access(OP_READ,  SZ_WORD, 1'b0, 32'h7C, 32'h0, "lw7c_kept");
    mem_access(OP_READ,  SZ_HALF, 1'b0, 32'h8000_0010, 32'h0, "lh_high_addr");

    dbg_access(5'd3, OP_WRITE, 32'h0, 32'hDEAD_BEEF, "dbg_vs_write");
    @(negedge clk); #1;
    check("dbg_vs_write_pulse", 32'(dbg_valid), 32'd0);
    mem_access(OP_READ, SZ_WORD, 1'b0, 32'h0, 32'h0, "lw0_no_write");

    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 9));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 159));
      op = (r <= 4) ? OP_WRITE : (r <= 8) ? OP_READ : (($urandom_range(0, 1) == 0) ? OP_IDLE : 2'b11);
      if (r == 0)
        dbg_access(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), a, $urandom, "rnd_dbg");
      else
        mem_access(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end

    // reset in the middle of traffic, with a write pending
    mem_access(OP_WRITE, SZ_WORD, 1'b0, 32'h8, 32'h1, "pre_rst_sw");
    mem_access(OP_READ,  SZ_WORD, 1'b0, 32'h8, 32'h0, "pre_rst_lw");
    mem_op = OP_WRITE; size = SZ_WORD; addr = 32'h8; wdata = 32'h5;
    #2 rst = 1'b1;
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_op = OP_IDLE;
    model_clear();
    wait_ready("reclear");
    mem_access(OP_READ, SZ_WORD, 1'b0, 32'h8, 32'h0, "lw8_after_reclear");
    dbg_access(5'd20, OP_IDLE, 32'h0, 32'h0, "dbg20_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised data memory for the pipelined MIPS core's MEM stage. It generalises the single-port word memory with:

- byte/halfword/word stores via byte enables;
- sign- or zero-extended sub-word loads;
- alignment and range error reporting;
- a sequential post-reset clear engine with a programmable preload word;
- a handshaked debug read port that has priority over pipeline traffic.

It sits between the EX/MEM and MEM/WB pipeline registers; the debug port is driven by the debug unit.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8, ≥ 16.
- DEPTH, 32, number of words; power of two.
- ADDR_W, 32, width of the pipeline byte address.
- PRELOAD_IDX, 20, word index written with PRELOAD_VAL at the end of the clear phase.
- PRELOAD_VAL, 32'h0000_0AAA, preload value.

Ports (derived widths: IDX_W = log2(DEPTH), OFF_W = log2(DATA_W/8)):
- clk, in, 1, clock; all state updates on the falling edge.
- rst, in, 1, reset: asynchronous, active-high.
- mem_op, in, 2, 00 idle, 01 write, 10 read, 11 idle.
- size, in, 2, 00 byte, 01 half, 10 word, 11 treated as word.
- unsigned_ld, in, 1, 1 = zero-extend sub-word load, 0 = sign-extend.
- addr, in, ADDR_W, byte address.
- wdata, in, DATA_W, store data, right-aligned.
- rdata, out, DATA_W, load result, right-aligned and extended.
- rvalid, out, 1, one-cycle pulse when rdata is updated.
- err, out, 1, registered error flag for the last accepted op.
- ready, out, 1, high once the clear phase has finished.
- dbg_on, in, 1, debug mode.
- dbg_addr, in, IDX_W, debug word index.
- dbg_data, out, DATA_W, debug read data.
- dbg_valid, out, 1, one-cycle pulse when dbg_data is updated.

## Operation
State machine (dmem_pkg::state_t):
- CLEAR: clr_idx counts 0..DEPTH-1, writing 0 to one word per edge. At DEPTH-1 the edge writes PRELOAD_VAL to PRELOAD_IDX (if PRELOAD_IDX == DEPTH-1, the preload wins) and the FSM goes to RUN.
- RUN: serves requests. It returns to CLEAR only on rst.

Request handling:
- While in CLEAR: ready=0, all mem_op and dbg_on requests are ignored, and rvalid, dbg_valid and err stay 0.
- In RUN, dbg_on=1: dbg_data ← mem[dbg_addr] and dbg_valid pulses. mem_op is ignored and no write occurs.
- In RUN, dbg_on=0, mem_op = write or read: the op is accepted.

Address decode:
- word index = addr[OFF_W +: IDX_W]; byte offset = addr[OFF_W-1:0].
- Error if any of:
  - size=half with offset[0]=1;
  - size=word with offset≠0;
  - addr ≥ DEPTH·DATA_W/8.
- An errored op sets err=1 and does not modify memory. A read with an error sets rdata=0 and still pulses rvalid.

Accepted ops:
- Write: only the byte lanes selected by size/offset are updated. A byte store writes wdata[7:0] into lane offset; a half store writes wdata[15:0] into lanes offset and offset+1.
- Read: the selected lanes are shifted to bit 0 and extended per unsigned_ld. Word reads ignore unsigned_ld. rvalid pulses. err=0 on every accepted non-error op.
- Idle: rvalid=0; err holds its last value.

## Timing
- Reset values: rdata=0, rvalid=0, err=0, ready=0, dbg_data=0, dbg_valid=0, state=CLEAR, clr_idx=0.
- The clear phase takes DEPTH falling edges after rst deasserts. ready rises on the edge that enters RUN.
- Read latency: result on the first falling edge after the request is presented. rvalid is high from that edge until the next falling edge.
- Write: memory is updated on the accepting edge. A read of the same word on the next edge returns the new data.
- Debug latency: same as read; dbg_valid lasts one cycle.
- rst asserted mid-clear or mid-access: outputs are forced to their reset values immediately, any pending write is discarded, and the clear restarts from index 0.
- Back-to-back accepted ops are legal on every edge; there is no stall output.

## Structure
- dmem_pkg:
  - OP_IDLE/OP_WRITE/OP_READ encodings;
  - SZ_BYTE/SZ_HALF/SZ_WORD encodings;
  - state_t {CLEAR, RUN}.
- Sub-module dmem_lane_align (combinational): from size, offset and wdata, produce the byte-enable vector and the lane-replicated write data; from the read word, offset, size and unsigned_ld, produce the extracted and extended load value.
- dmem_bank holds the storage array, the FSM, the clear counter and the output registers.

## Test plan
- Reset, then wait DEPTH edges → ready rises on edge 32; a debug read of index 20 gives dbg_data=0x00000AAA; a debug read of index 5 gives 0.
- SW 0x8badf00d @0x10, then LB @0x13 → rdata=0xFFFFFF8B; LBU @0x13 → 0x0000008B; LH @0x10 → 0xFFFFF00D; LHU @0x12 → 0x00008BAD.
- SW 0 @0x0, SB 0x1234 @0x1, SH 0xBEEF @0x2, then LW @0x0 → 0xBEEF3400, err=0.
- LW @0x6 → err=1, rdata=0, rvalid pulses; SH @0x81 → err=1 and memory is unchanged (LW @0x80 → err=1 because it is out of range; LW @0x7C → its old value).
- dbg_on=1 together with mem_op=write @0x0 → no write (LW @0x0 afterwards returns its old value); dbg_valid pulses exactly one cycle.
- After SW 0x1 @0x8, assert rst for one cycle during a read → rvalid=0 and ready=0 immediately; after the re-clear, LW @0x8 → 0.
